// File: rtl/mul_iterative_x_unit_pkg.sv
// Shared execute-pipe types: FSM state encoding and the issued micro-op type.
package XUnitPkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef enum logic [3:0] {
        UOP_ADD  = 4'd0,
        UOP_SUB  = 4'd1,
        UOP_MUL  = 4'd2,
        UOP_MULH = 4'd3,
        UOP_DIV  = 4'd4,
        UOP_REM  = 4'd5
    } rv_uop;

endpackage

// File: rtl/mul_iterative_x_unit_dpath.sv
// Radix-2 shift-add multiplier datapath; one partial-product step per cycle.
// Latency: one cycle per step, at most 32; the caller stalls via step_i.
module mul_iterative_x_unit_dpath
    import XUnitPkg::*;
(
    input  logic            clk,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] acc_o,
    output logic            last_step_o
);

    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = op1_i;
            mplier_d = op2_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
        end
    end

    // No reset: contents are only meaningful after a load.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
    end

    // Stop once no set multiplier bits remain, so short op2 values finish early.
    assign last_step_o = ((mplier_q >> 1) == '0) || (cnt_q == 5'd31);
    assign acc_o       = acc_q;

endmodule

// File: rtl/mul_iterative_x_unit.sv
// Iterative MUL execute pipe: one op in flight, low 32 product bits to writeback.
// Result appears 1+n cycles after accept (n = CALC steps); W outputs hold while w_rdy_i is low.
module mul_iterative_x_unit
    import XUnitPkg::*;
#(
    parameter int unsigned p_seq_num_bits = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    // issue (D->X)
    input  logic                      d_val_i,
    output logic                      d_rdy_o,
    input  logic [31:0]               d_pc_i,
    input  logic [31:0]               d_op1_i,
    input  logic [31:0]               d_op2_i,
    input  rv_uop                     d_uop_i,
    input  logic [4:0]                d_waddr_i,
    input  logic [p_seq_num_bits-1:0] d_seq_num_i,
    // writeback (X->W)
    output logic                      w_val_o,
    input  logic                      w_rdy_i,
    output logic [31:0]               w_pc_o,
    output logic [p_seq_num_bits-1:0] w_seq_num_o,
    output logic [4:0]                w_waddr_o,
    output logic [31:0]               w_wdata_o,
    output logic                      w_wen_o
);

    mul_state_t state_q, state_d;

    logic                      load, step, last_step;
    logic [31:0]               pc_q;
    logic [p_seq_num_bits-1:0] seq_num_q;
    logic [4:0]                waddr_q;
    logic [31:0]               acc;

    // Every uop routed here is computed as MUL.
    logic unused_uop;
    assign unused_uop = ^d_uop_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (d_val_i && d_rdy_o) state_d = CALC;
            CALC:    if (last_step)          state_d = DONE;
            DONE:    if (w_val_o && w_rdy_i) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        d_rdy_o = (state_q == IDLE) && !rst;
        w_val_o = (state_q == DONE);
        load    = d_val_i && d_rdy_o;
        step    = (state_q == CALC);
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pc_q      <= d_pc_i;
            seq_num_q <= d_seq_num_i;
            waddr_q   <= d_waddr_i;
        end
    end

    mul_iterative_x_unit_dpath u_dpath (
        .clk         (clk),
        .load_i      (load),
        .step_i      (step),
        .op1_i       (d_op1_i),
        .op2_i       (d_op2_i),
        .acc_o       (acc),
        .last_step_o (last_step)
    );

    // Straight from registers, so W is stable for as long as DONE persists.
    assign w_pc_o      = pc_q;
    assign w_seq_num_o = seq_num_q;
    assign w_waddr_o   = waddr_q;
    assign w_wdata_o   = acc;
    assign w_wen_o     = (waddr_q != 5'd0);

`ifndef SYNTHESIS
    function automatic string trace();
        if (state_q == CALC)
            return $sformatf("%20s", "*");
        else if (w_val_o && w_rdy_i)
            return $sformatf("%20s", $sformatf("%08h", w_wdata_o));
        else
            return $sformatf("%20s", "");
    endfunction
`endif

endmodule
